// File: rtl/encoder_position_ctrl_if.sv
// Target-position handshake between a motion planner (master) and the position tracker (slave).
interface encoder_position_ctrl_if #(
    parameter int POS_W = 32
);
    logic                    tgt_valid;
    logic signed [POS_W-1:0] tgt_data;
    logic                    tgt_ready;

    modport master (output tgt_valid, output tgt_data, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/encoder_position_ctrl.sv
// Homing sequencer and signed position tracker fed by a quadrature decoder's direction codes.
// Define SOFT_LIMIT_EN to discard steps beyond POS_MIN/POS_MAX and fault instead.
module encoder_position_ctrl #(
    parameter int POS_W        = 32,
    parameter int HOME_TIMEOUT = 1000000,
    parameter int VEL_WINDOW   = 10000,
    parameter int TOL          = 2,
    parameter int POS_MIN      = -32768,
    parameter int POS_MAX      = 32767
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              dir,
    input  logic                    home_sw,
    input  logic                    start_home,
    input  logic                    clr_fault,
    encoder_position_ctrl_if.slave  tgt,
    output logic signed [POS_W-1:0] pos,
    output logic                    at_target,
    output logic signed [POS_W-1:0] vel,
    output logic                    vel_valid,
    output logic [7:0]              err_cnt,
    output logic [1:0]              state
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOMING = 2'b01,
        TRACK  = 2'b10,
        FAULT  = 2'b11
    } state_t;

    localparam int TO_W  = $clog2(HOME_TIMEOUT + 1);
    localparam int WIN_W = $clog2(VEL_WINDOW);
    localparam int PW1   = POS_W + 1;
    localparam logic [TO_W-1:0]         TO_LAST  = TO_W'(HOME_TIMEOUT - 1);
    localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(VEL_WINDOW - 1);
    localparam logic signed [POS_W-1:0] LIM_LO   = POS_W'(POS_MIN);
    localparam logic signed [POS_W-1:0] LIM_HI   = POS_W'(POS_MAX);
    localparam logic signed [POS_W-1:0] ONE      = POS_W'(1);
    localparam logic [PW1-1:0]          TOL_V    = PW1'(TOL);

    state_t                  cur_st, nxt_st;
    logic                    sync1, sync2, sync_prev;
    logic                    home_rise;
    logic [TO_W-1:0]         to_cnt;
    logic [WIN_W-1:0]        win_cnt;
    logic signed [POS_W-1:0] target, nxt_target, nxt_pos, pos_snap;
    logic                    step_up, step_dn, limit_en, limit_hit, track_entry;
    logic [PW1-1:0]          diff, diff_abs;

    assign state         = cur_st;
    assign tgt.tgt_ready = (cur_st == TRACK);
    assign home_rise     = sync2 & ~sync_prev;
    assign step_up       = (dir == 2'b01);
    assign step_dn       = (dir == 2'b10);
    assign track_entry   = (cur_st != TRACK) && (nxt_st == TRACK);

`ifdef SOFT_LIMIT_EN
    assign limit_en = 1'b1;
`else
    assign limit_en = 1'b0;
`endif

    // Limits lie inside the representable range, so a blocked step can never have wrapped.
    assign limit_hit = limit_en && ((step_up && (pos >= LIM_HI)) || (step_dn && (pos <= LIM_LO)));

    // NOTE: every output of this block is assigned a default first so no latch is inferred.
    always_comb begin
        nxt_st     = cur_st;
        nxt_pos    = pos;
        nxt_target = target;
        case (cur_st)
            IDLE: begin
                if (start_home) nxt_st = HOMING;
            end
            HOMING: begin
                if (home_rise) begin
                    nxt_st     = TRACK;
                    nxt_pos    = '0;
                    nxt_target = '0;
                end else if (to_cnt == TO_LAST) begin
                    nxt_st = FAULT;
                end
            end
            TRACK: begin
                if (tgt.tgt_valid && tgt.tgt_ready) nxt_target = tgt.tgt_data;
                if (start_home)   nxt_st  = HOMING;
                else if (limit_hit) nxt_st = FAULT;
                else if (step_up) nxt_pos = pos + ONE;
                else if (step_dn) nxt_pos = pos - ONE;
            end
            FAULT: begin
                if (clr_fault) nxt_st = IDLE;
            end
            default: nxt_st = IDLE;
        endcase
    end

    // One extra bit keeps the distance exact even between the two range extremes.
    assign diff     = {nxt_pos[POS_W-1], nxt_pos} - {nxt_target[POS_W-1], nxt_target};
    assign diff_abs = diff[POS_W] ? (-diff) : diff;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st    <= IDLE;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            to_cnt    <= '0;
            win_cnt   <= '0;
            pos       <= '0;
            target    <= '0;
            pos_snap  <= '0;
            vel       <= '0;
            vel_valid <= 1'b0;
            at_target <= 1'b0;
            err_cnt   <= '0;
        end else begin
            cur_st    <= nxt_st;
            sync1     <= home_sw;
            sync2     <= sync1;
            sync_prev <= sync2;
            pos       <= nxt_pos;
            target    <= nxt_target;
            at_target <= (nxt_st == TRACK) && (diff_abs <= TOL_V);
            to_cnt    <= (cur_st == HOMING) ? to_cnt + TO_W'(1) : '0;
            vel_valid <= 1'b0;

            if (dir == 2'b11 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

            if (track_entry) begin
                win_cnt  <= '0;
                pos_snap <= '0;
                vel      <= '0;
            end else if (cur_st == TRACK) begin
                if (win_cnt == WIN_LAST) begin
                    win_cnt   <= '0;
                    vel       <= pos - pos_snap;
                    pos_snap  <= pos;
                    vel_valid <= 1'b1;
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_encoder_position_ctrl.sv
// Scoreboard bench for encoder_position_ctrl: homing, timeout, counting, targets, velocity, wrap/limit, reset.
module tb_encoder_position_ctrl;
    localparam int POS_W        = 8;
    localparam int HOME_TIMEOUT = 100;
    localparam int VEL_WINDOW   = 20;
    localparam int TOL          = 0;
    localparam int POS_MIN      = -100;
    localparam int POS_MAX      = 100;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [1:0]              dir;
    logic                    home_sw, start_home, clr_fault;
    logic signed [POS_W-1:0] pos, vel;
    logic                    at_target, vel_valid;
    logic [7:0]              err_cnt;
    logic [1:0]              state;

    encoder_position_ctrl_if #(.POS_W(POS_W)) tgt_bus ();

    encoder_position_ctrl #(
        .POS_W(POS_W), .HOME_TIMEOUT(HOME_TIMEOUT), .VEL_WINDOW(VEL_WINDOW),
        .TOL(TOL), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dir(dir), .home_sw(home_sw),
        .start_home(start_home), .clr_fault(clr_fault), .tgt(tgt_bus),
        .pos(pos), .at_target(at_target), .vel(vel), .vel_valid(vel_valid),
        .err_cnt(err_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic signed [POS_W-1:0] m_pos;
    int                      m_err;
    int                      pos_q[$];
    int                      vel_q[$];

    logic vel_chk_en = 1'b0;
    int   vel_seen   = 0;
    int   vel_base   = 0;
    int   last_vel_cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Velocity monitor: the first pulse after a pattern change spans a mixed window and is skipped.
    always @(negedge clk) begin
        if (vel_chk_en && vel_valid) begin
            if (vel_seen != vel_base && vel_q.size() > 0) begin
                check("vel", int'(vel), vel_q.pop_front());
                check("vel_period", cyc - last_vel_cyc, VEL_WINDOW);
            end
            vel_seen     <= vel_seen + 1;
            last_vel_cyc <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] d);
        dir = d;
        if (d == 2'b01) m_pos++;
        else if (d == 2'b10) m_pos--;
        else if (d == 2'b11 && m_err < 255) m_err++;
        pos_q.push_back(int'(m_pos));
        tick();
        dir = 2'b00;
        check("pos_step", int'(pos), pos_q.pop_front());
    endtask

    task automatic do_home();
        int n;
        home_sw = 1'b0;
        repeat (4) tick();
        start_home = 1'b1;
        tick();
        start_home = 1'b0;
        check("homing_state", int'(state), 1);
        repeat (50) tick();
        home_sw = 1'b1;
        n = 0;
        while (state != 2'b10 && n < 10) begin
            tick();
            n++;
        end
        check("home_track_state", int'(state), 2);
        m_pos = '0;
        check("home_pos", int'(pos), 0);
        check("home_tgt_ready", int'(tgt_bus.tgt_ready), 1);
    endtask

    task automatic send_target(input int t);
        tgt_bus.tgt_valid = 1'b1;
        tgt_bus.tgt_data  = POS_W'(t);
        check("tgt_ready_offer", int'(tgt_bus.tgt_ready), 1);
        tick();
        tgt_bus.tgt_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        dir = 2'b00;
        home_sw = 1'b0;
        start_home = 1'b0;
        clr_fault = 1'b0;
        tgt_bus.tgt_valid = 1'b0;
        tgt_bus.tgt_data  = '0;
        m_pos = '0;
        m_err = 0;
        repeat (3) tick();
        check("rst_state", int'(state), 0);
        check("rst_pos", int'(pos), 0);
        check("rst_vel", int'(vel), 0);
        check("rst_vel_valid", int'(vel_valid), 0);
        check("rst_err", int'(err_cnt), 0);
        check("rst_at_target", int'(at_target), 0);
        check("rst_tgt_ready", int'(tgt_bus.tgt_ready), 0);
        rst_n = 1'b1;
        tick();

        // Homing timeout: FAULT exactly HOME_TIMEOUT cycles after start_home is taken.
        start_home = 1'b1;
        tick();
        start_home = 1'b0;
        n = 0;
        while (state != 2'b11 && n < 200) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, HOME_TIMEOUT);
        check("fault_tgt_ready", int'(tgt_bus.tgt_ready), 0);
        start_home = 1'b1;
        tick();
        start_home = 1'b0;
        check("fault_ignores_start", int'(state), 3);
        clr_fault  = 1'b1;
        start_home = 1'b1;
        tick();
        clr_fault  = 1'b0;
        start_home = 1'b0;
        check("clr_fault_idle", int'(state), 0);

        // Homing and counting.
        do_home();
        repeat (7) step(2'b01);
        repeat (3) step(2'b10);
        repeat (2) step(2'b11);
        check("track_pos4", int'(pos), 4);
        check("track_err2", int'(err_cnt), m_err);
        send_target(5);
        check("at_target_off", int'(at_target), 0);
        step(2'b01);
        check("at_target_on", int'(at_target), 1);
        step(2'b01);
        check("at_target_past", int'(at_target), 0);
        step(2'b10);
        check("at_target_back", int'(at_target), 1);
        repeat (260) step(2'b11);
        check("err_saturate", int'(err_cnt), 255);
        check("err_keeps_track", int'(state), 2);

        // Velocity: one step every 4th cycle over a 20-cycle window.
        vel_chk_en = 1'b1;
        vel_base = vel_seen;
        repeat (4) vel_q.push_back(5);
        for (int i = 0; i < 100; i++) begin
            dir = (i % 4 == 0) ? 2'b01 : 2'b00;
            tick();
        end
        check("vel_up_drained", vel_q.size(), 0);
        vel_base = vel_seen;
        repeat (4) vel_q.push_back(-5);
        for (int i = 0; i < 100; i++) begin
            dir = (i % 4 == 0) ? 2'b10 : 2'b00;
            tick();
        end
        dir = 2'b00;
        check("vel_dn_drained", vel_q.size(), 0);
        vel_chk_en = 1'b0;

        // Re-home with a home rise coinciding with dir=01: the step must be dropped.
        home_sw = 1'b0;
        start_home = 1'b1;
        tick();
        start_home = 1'b0;
        check("rehome_state", int'(state), 1);
        check("rehome_pos_frozen", int'(pos), 5);
        dir = 2'b01;
        repeat (4) tick();
        check("homing_pos_frozen", int'(pos), 5);
        home_sw = 1'b1;
        tick();
        tick();
        check("rise_not_yet", int'(state), 1);
        tick();
        dir = 2'b00;
        check("rise_track", int'(state), 2);
        check("rise_pos_zero", int'(pos), 0);
        m_pos = '0;

        // Asynchronous reset in the middle of tracking.
        repeat (3) step(2'b01);
        send_target(3);
        check("pre_rst_at_target", int'(at_target), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_pos", int'(pos), 0);
        check("mid_rst_vel", int'(vel), 0);
        check("mid_rst_vel_valid", int'(vel_valid), 0);
        check("mid_rst_err", int'(err_cnt), 0);
        check("mid_rst_at_target", int'(at_target), 0);
        check("mid_rst_tgt_ready", int'(tgt_bus.tgt_ready), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        m_err = 0;
        tick();

`ifdef SOFT_LIMIT_EN
        do_home();
        repeat (POS_MAX) step(2'b01);
        dir = 2'b01;
        tick();
        dir = 2'b00;
        check("limit_pos_hold", int'(pos), POS_MAX);
        check("limit_fault", int'(state), 3);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("limit_clear", int'(state), 0);
`else
        do_home();
        repeat (127) step(2'b01);
        check("wrap_max", int'(pos), 127);
        step(2'b01);
        check("wrap_min", int'(pos), -128);
        check("wrap_no_fault", int'(state), 2);
        step(2'b10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
